// File: rtl/mult_pkg.sv
// Shared definitions for the 4-bit shift-and-add multiplier: controller states,
// step count and the default watchdog limit used by controller, Counter and datapath.
package mult_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_SETTLE = 3'd2,
      S_ITER   = 3'd3,
      S_DONE   = 3'd4,
      S_ERR    = 3'd5
   } state_t;

   localparam int N_BITS      = 4;
   localparam int TIMEOUT_DEF = 15;
   localparam int TO_W_DEF    = 4;

endpackage

// File: rtl/mult_control.sv
// Sequencer for the shift-and-add multiplier: drives Counter load and datapath
// add/shift strobes, offers a start/done/ack handshake and a watchdog error.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | Counter cleared, operands loaded, accumulator cleared
// SETTLE | one dead cycle while the Counter's registered k catches up
// ITER   | one add/shift step per cycle until k, watchdog running
// DONE   | product valid, waiting for ack
// ERR    | watchdog expired before k, waiting for ack
module mult_control
   import mult_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int TO_W    = TO_W_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic ack,
   input  logic k,
   input  logic q0,
   output logic load,
   output logic add,
   output logic shift,
   output logic busy,
   output logic done,
   output logic err
);

   localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT - 1);

   state_t          state;
   state_t          state_nxt;
   logic [TO_W-1:0] wd;
   logic [TO_W-1:0] wd_nxt;
   logic            wd_expired;

   assign wd_expired = (wd == WD_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         wd    <= '0;
      end else begin
         state <= state_nxt;
         wd    <= wd_nxt;
      end
   end

   // Strobes depend only on state (reset forces IDLE), so they drop asynchronously with rst_n.
   always_comb begin
      state_nxt = state;
      wd_nxt    = '0;
      load      = 1'b0;
      add       = 1'b0;
      shift     = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      err       = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (start) state_nxt = S_LOAD;
         end
         S_LOAD: begin
            load      = 1'b1;
            busy      = 1'b1;
            state_nxt = S_SETTLE;
         end
         S_SETTLE: begin
            busy      = 1'b1;
            state_nxt = S_ITER;
         end
         S_ITER: begin
            busy = 1'b1;
            if (k) begin
               state_nxt = S_DONE;
            end else begin
               shift  = 1'b1;
               add    = q0;
               wd_nxt = wd + 1'b1;
               // the step of the expiring cycle still fires
               if (wd_expired) begin
                  state_nxt = S_ERR;
                  wd_nxt    = '0;
               end
            end
         end
         S_DONE: begin
            done = 1'b1;
            if (ack) state_nxt = S_IDLE;
         end
         S_ERR: begin
            err = 1'b1;
            if (ack) state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

endmodule

// File: doc/mult_control.md
Name: mult_control

Overview:
- Control unit for the 4-bit shift-and-add multiplier.
- Sits directly upstream of the iteration Counter. It drives the Counter's load input and consumes its k flag.
- In the same cycles it sequences the datapath (accumulator/multiplier shift register) through load, add and shift strobes.
- Provides a start/done/ack handshake to the surrounding system, plus a watchdog error flag.

Parameters:
- TIMEOUT, 15: maximum cycles allowed in ITER before k must arrive; exceeding it raises err.
- TO_W, 4: width of the watchdog counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a multiplication; sampled only in IDLE.
- ack  input  1  consumer acknowledges the result; sampled only in DONE or ERR.
- k  input  1  Counter terminal flag; registered in the Counter and sticky until the next load.
- q0  input  1  LSB of the multiplier shift register.
- load  output  1  drives the Counter load input and the datapath operand/accumulator clear.
- add  output  1  datapath: accumulator <= accumulator + multiplicand on this edge.
- shift  output  1  datapath: shift {accumulator, multiplier} right one bit on this edge.
- busy  output  1  high from LOAD through ITER.
- done  output  1  result valid; held until ack.
- err  output  1  watchdog expired; held until ack.

Behaviour:
- Reset (rst_n low, asynchronous, including mid-operation):
  - state = IDLE, watchdog = 0.
  - All outputs 0 immediately.
  - No step strobe may fire during reset.
- States: IDLE, LOAD, SETTLE, ITER, DONE, ERR. State and watchdog are registered.
- Outputs:
  - load, busy, done and err decode from state (Moore).
  - add and shift are Mealy: shift = (state==ITER) & ~k; add = shift & q0.
- IDLE:
  - start=1 -> LOAD.
  - Otherwise stay. ack is ignored.
- LOAD: load=1, busy=1, one cycle -> SETTLE. The Counter clears on this edge.
- SETTLE: busy=1, no strobes, one cycle -> ITER. This absorbs the Counter's one-cycle k latency.
- ITER, k=0:
  - shift=1, add=q0.
  - watchdog increments.
  - If watchdog == TIMEOUT-1 on this edge -> ERR, and the strobes of that cycle still fire.
- ITER, k=1: no strobes -> DONE. The watchdog clears.
- Timing of a normal run:
  - The load edge is E0.
  - Exactly 4 step edges follow, at E2..E5.
  - k is seen high after E5, giving ITER -> DONE at E6.
  - done is high from E6 onward.
  - Latency from start sampled to done = 7 cycles.
- DONE: done=1.
  - ack=1 -> IDLE.
  - start is ignored; a new start is only sampled after returning to IDLE, the cycle after ack.
- ERR: err=1, all strobes 0.
  - ack=1 -> IDLE.
- Simultaneous events:
  - start asserted while busy is ignored; no restart.
  - ack outside DONE/ERR is ignored.
  - start and ack high together in DONE: ack wins -> IDLE. start is re-sampled next cycle in IDLE.
- k high already in SETTLE (stale): ignored, because only ITER samples k.
- Strobe exclusivity: load never overlaps add or shift.

Decomposition:
- Shared package mult_pkg holds:
  - the state enum (IDLE..ERR, 3-bit encoding);
  - the step-count constant N_BITS=4;
  - the default TIMEOUT constant, which the datapath and Counter also use.
- No sub-module is needed. The watchdog is an inline counter.
- The FSM plus watchdog fits in one module of roughly 150 lines.

Test Plan:
- Nominal, with Counter and a behavioural datapath: reset, start pulse, multiplicand 4'd13, multiplier 4'd11 (q0 sequence 1,1,0,1) -> load at E0, shift at E2..E5, add at E2, E3, E5; done at E6; product 8'd143; ack returns to IDLE next cycle.
- Zero multiplier 4'd0 -> add never asserts; 4 shifts; done at E6; product 0.
- start held high through the whole run and during DONE, then ack -> no restart while busy; IDLE for one cycle after ack; then LOAD again since start is still high.
- Watchdog: k tied to 0 -> shift asserted for exactly TIMEOUT cycles in ITER, then err=1, strobes 0; ack -> IDLE, err=0.
- Reset mid-ITER (rst_n low after E3) -> all outputs 0 asynchronously, before the next edge; after release, stay in IDLE until start; a fresh run then completes with correct timing.
- start and ack both high in DONE -> IDLE for exactly one cycle, then LOAD.
